// File: rtl/op2_shift_ctrl_pkg.sv
// Shared types and constants for the DP second-operand sequencer.
package op2_shift_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROT,
    ST_RD_RS,
    ST_RD_RM,
    ST_RESULT
  } state_e;

  // Shift type field, as found in inst[6:5] and shifter op[2:1]
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Shifter op used for the I-form rotate: ROR, register form
  localparam logic [2:0] OP_ROR_REG = 3'b111;

  // Instruction field positions
  localparam int BIT_I    = 25;
  localparam int BIT_REG  = 4;
  localparam int RS_HI    = 11;
  localparam int RS_LO    = 8;
  localparam int RM_HI    = 3;
  localparam int RM_LO    = 0;
  localparam int SHIMM_HI = 11;
  localparam int SHIMM_LO = 7;
  localparam int ROT_HI   = 11;
  localparam int ROT_LO   = 8;
  localparam int IMM8_HI  = 7;
  localparam int IMM8_LO  = 0;
  localparam int SHOP_HI  = 6;
  localparam int SHOP_LO  = 4;

  localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/op2_shift_ctrl_shifter.sv
// Combinational ARM barrel shifter: op[2:1] = shift type, op[0] = register form.
module op2_shift_ctrl_shifter
  import op2_shift_ctrl_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] in_i,
  input  logic [4:0]  sh_imm_i,
  input  logic [7:0]  sh_reg_i,
  input  logic        cin_i,
  output logic [31:0] out_o,
  output logic        cout_o
);

  logic [1:0]         typ;
  logic               reg_form;
  logic [7:0]         amt;
  logic [5:0]         asr_amt;
  logic [4:0]         rot;
  logic [32:0]        lsl_w;
  logic [32:0]        lsr_w;
  logic signed [32:0] asr_w;
  logic [31:0]        ror_w;

  // Effective amount plus all four shift results; an extra bit carries the last bit shifted out
  always_comb begin
    typ      = op_i[2:1];
    reg_form = op_i[0];
    if (reg_form) begin
      amt = sh_reg_i;
    end else if ((sh_imm_i == 5'd0) && ((typ == SH_LSR) || (typ == SH_ASR))) begin
      amt = 8'd32;
    end else begin
      amt = {3'b000, sh_imm_i};
    end
    asr_amt = (amt > 8'd32) ? 6'd32 : amt[5:0];
    rot     = amt[4:0];
    lsl_w   = {1'b0, in_i} << amt;
    lsr_w   = {in_i, 1'b0} >> amt;
    asr_w   = $signed({in_i, 1'b0}) >>> asr_amt;
    ror_w   = (in_i >> rot) | (in_i << (6'd32 - {1'b0, rot}));
  end

  // Select result; zero amount passes the operand with carry-in, ROR #0 is RRX
  always_comb begin
    out_o  = in_i;
    cout_o = cin_i;
    if (!reg_form && (typ == SH_ROR) && (sh_imm_i == 5'd0)) begin
      out_o  = {cin_i, in_i[31:1]};
      cout_o = in_i[0];
    end else if (amt != 8'd0) begin
      case (typ)
        SH_LSL: begin
          out_o  = lsl_w[31:0];
          cout_o = lsl_w[32];
        end
        SH_LSR: begin
          out_o  = lsr_w[32:1];
          cout_o = lsr_w[0];
        end
        SH_ASR: begin
          out_o  = asr_w[32:1];
          cout_o = asr_w[0];
        end
        default: begin
          out_o  = ror_w;
          cout_o = ror_w[31];
        end
      endcase
    end
  end

endmodule

// File: rtl/op2_shift_ctrl.sv
// Sequences register reads and the barrel shifter to build the DP second operand.
module op2_shift_ctrl
  import op2_shift_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_OFS_IMM = 32'd8,
  parameter logic [31:0] PC_OFS_REG = 32'd12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_inst,
  input  logic [31:0] req_pc,
  input  logic        req_cflag,
  output logic        rf_ren,
  output logic [3:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_op2,
  output logic        res_carry
);

  state_e      state_q;
  logic [11:0] inst_q;
  logic [31:0] pc_q;
  logic        cflag_q;
  logic [7:0]  rs_q;
  logic        rf_ren_q;
  logic [3:0]  rf_addr_q;
  logic        res_valid_q;
  logic [31:0] res_op2_q;
  logic        res_carry_q;

  logic [2:0]  sh_op;
  logic [31:0] sh_in;
  logic [4:0]  sh_imm;
  logic [7:0]  sh_reg;
  logic [31:0] sh_out;
  logic        sh_cout;
  logic [31:0] pc_imm;
  logic [31:0] pc_reg;
  logic [31:0] rm_val;
  logic        unused_inst_bits;

  // Only I, the shift/operand fields and [11:0] matter to this stage
  assign unused_inst_bits = ^{req_inst[31:26], req_inst[24:12]};

  assign pc_imm = pc_q + PC_OFS_IMM;
  assign pc_reg = pc_q + PC_OFS_REG;

  // Rm operand: r15 reads as the pipelined PC, which is further ahead for register shifts
  always_comb begin
    rm_val = rf_data;
    if (inst_q[RM_HI:RM_LO] == REG_PC) begin
      rm_val = inst_q[BIT_REG] ? pc_reg : pc_imm;
    end
  end

  // Shifter input mux: the I-form rotate reuses register-form ROR by 2*rot
  always_comb begin
    sh_op  = inst_q[SHOP_HI:SHOP_LO];
    sh_in  = rm_val;
    sh_imm = inst_q[SHIMM_HI:SHIMM_LO];
    sh_reg = rs_q;
    if (state_q == ST_ROT) begin
      sh_op  = OP_ROR_REG;
      sh_in  = {24'd0, inst_q[IMM8_HI:IMM8_LO]};
      sh_imm = 5'd0;
      sh_reg = {3'b000, inst_q[ROT_HI:ROT_LO], 1'b0};
    end
  end

  op2_shift_ctrl_shifter u_shifter (
    .op_i     (sh_op),
    .in_i     (sh_in),
    .sh_imm_i (sh_imm),
    .sh_reg_i (sh_reg),
    .cin_i    (cflag_q),
    .out_o    (sh_out),
    .cout_o   (sh_cout)
  );

  // Control FSM with registered read-port and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      inst_q      <= '0;
      pc_q        <= '0;
      cflag_q     <= 1'b0;
      rs_q        <= '0;
      rf_ren_q    <= 1'b0;
      rf_addr_q   <= '0;
      res_valid_q <= 1'b0;
      res_op2_q   <= '0;
      res_carry_q <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      rf_ren_q    <= 1'b0;
      rf_addr_q   <= '0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            inst_q  <= req_inst[11:0];
            pc_q    <= req_pc;
            cflag_q <= req_cflag;
            if (req_inst[BIT_I]) begin
              state_q <= ST_ROT;
            end else if (req_inst[BIT_REG]) begin
              state_q   <= ST_RD_RS;
              rf_ren_q  <= 1'b1;
              rf_addr_q <= req_inst[RS_HI:RS_LO];
            end else begin
              state_q   <= ST_RD_RM;
              rf_ren_q  <= 1'b1;
              rf_addr_q <= req_inst[RM_HI:RM_LO];
            end
          end
        end
        ST_ROT: begin
          res_op2_q   <= sh_out;
          res_carry_q <= sh_cout;
          res_valid_q <= 1'b1;
          state_q     <= ST_RESULT;
        end
        ST_RD_RS: begin
          rs_q      <= (inst_q[RS_HI:RS_LO] == REG_PC) ? pc_imm[7:0] : rf_data[7:0];
          rf_addr_q <= inst_q[RM_HI:RM_LO];
          state_q   <= ST_RD_RM;
        end
        ST_RD_RM: begin
          res_op2_q   <= sh_out;
          res_carry_q <= sh_cout;
          res_valid_q <= 1'b1;
          rf_ren_q    <= 1'b0;
          rf_addr_q   <= '0;
          state_q     <= ST_RESULT;
        end
        ST_RESULT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rf_ren    = rf_ren_q;
  assign rf_addr   = rf_addr_q;
  assign res_valid = res_valid_q;
  assign res_op2   = res_op2_q;
  assign res_carry = res_carry_q;

endmodule

// File: doc/op2_shift_ctrl.md
Name: op2_shift_ctrl

Overview:
- Sequences the barrel shifter to produce the ARM data-processing second operand (shifter_operand) and shifter carry-out.
- Decodes a DP instruction and reads Rs and/or Rm through one shared register-file read port, one register per cycle.
- Drives the shifter and registers the result toward the ALU stage with a valid/ready handshake.
- Sits between decode and execute and owns the only shifter instance.

Parameters:
- PC_OFS_IMM, 8, value added to req_pc when Rm=r15 and the shift is immediate or the operand is I-form.
- PC_OFS_REG, 12, value added to req_pc when Rm=r15 and the shift is register-specified.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort of any request in flight.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_inst  in  32  DP instruction; uses bit 25 (I), [11:0].
- req_pc  in  32  address of req_inst.
- req_cflag  in  1  CPSR.C at issue.
- rf_ren  out  1  register read enable.
- rf_addr  out  4  register read address.
- rf_data  in  32  read data, combinational, same cycle as rf_addr.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts the result.
- res_op2  out  32  shifter_operand.
- res_carry  out  1  shifter carry-out.

Behaviour:
- Reset: async, active-high, forces state=IDLE, res_valid=0, res_op2=0, res_carry=0, rf_ren=0, rf_addr=0. Reset mid-operation discards the request.
- States: IDLE, ROT, RD_RS, RD_RM, RESULT. req_ready=1 only in IDLE.
- IDLE: on req_valid, latch inst, pc and cflag. Next state:
  - ROT if I=1.
  - RD_RS if I=0 and inst[4]=1.
  - RD_RM otherwise.
- ROT: shifter op=3'b111, in={24'b0,imm8}, sh_reg={3'b0,rot4,1'b0}, cin=latched C. This gives carry=C when rot=0, else result[31]. Register the result, then go to RESULT.
- RD_RS: rf_ren=1, rf_addr=inst[11:8]. Latch rs_q=rf_data[7:0], then go to RD_RM. If Rs=r15, rs_q=(pc+PC_OFS_IMM)[7:0]. Do not drive rf_data for r15.
- RD_RM: rf_ren=1, rf_addr=inst[3:0]. Operand is rf_data, or pc+PC_OFS_IMM / pc+PC_OFS_REG (reg form) when Rm=r15; add modulo 2^32.
  - Shifter op=inst[6:4], sh_imm=inst[11:7], sh_reg=rs_q, cin=latched C.
  - Register out/cout into res_op2/res_carry, then go to RESULT.
- Shifter encoding: op[2:1]=type, op[0]=register form.
  - Imm LSR/ASR #0 means #32.
  - ROR #0 means RRX.
  - Register shift by 0 passes the operand through with carry=C.
  - Register amount ≥32 saturates per ARM ARM.
- RESULT: res_valid=1, res_op2/res_carry held stable. On res_ready go to IDLE; no accept in the same cycle.
- Latency from accept to res_valid: 2 cycles (I-form, imm shift), 3 cycles (register shift). Throughput: one request per latency+1 cycles with res_ready tied high.
- rf_ren=0 and rf_addr=0 outside RD_RS/RD_RM.
- flush in any state: next state IDLE, res_valid=0 next cycle; the result is discarded. Flush takes priority over res_ready and over req_valid in IDLE (no accept in a flush cycle).
- Backpressure: res_ready=0 holds RESULT indefinitely.

Decomposition:
- Shared package holds:
  - State enum.
  - Shift-type constants LSL=2'b00, LSR=2'b01, ASR=2'b10, ROR=2'b11.
  - Instruction field bit positions (I=25, REG=4, RS=11:8, RM=3:0, SHIMM=11:7, ROT=11:8, IMM8=7:0).
  - REG_PC=4'd15.
- One sub-module: the existing shifter, instantiated once. The r15 substitution and FSM stay in this block.

Test Plan:
- I-form imm8=0xFF, rot=4, C=0 -> res_op2=0xFF000000, res_carry=1, res_valid 2 cycles after accept, rf_ren never asserted.
- MOV-style LSL #0, Rm=r2=0x80000001, C=1 -> res_op2=0x80000001, res_carry=1.
- LSR #0 (i.e. #32), Rm=0x80000000 -> res_op2=0, res_carry=1.
- ROR #0 (RRX), Rm=0x00000003, C=1 -> res_op2=0x80000001, res_carry=1.
- Register LSL, Rs=r3=0x00000121 (amount 33), Rm=r4=0xFFFFFFFF:
  - rf_addr sequence 3 then 4.
  - res_op2=0, res_carry=0, res_valid 3 cycles after accept.
  - Repeat with Rs=0x100 (amount 0), C=1 -> res_op2=0xFFFFFFFF, res_carry=1.
- Rm=r15 with req_pc=0x1000:
  - Imm LSL #0 -> 0x00001008.
  - Register shift by Rs=0 -> 0x0000100C.
  - flush during RD_RM -> res_valid stays 0 and req_ready=1 next cycle.
  - rst pulse during RESULT with res_ready=0 -> res_valid=0 immediately.
